// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional two-entry skid buffer,
// bubble-masked control payload and synchronous flush.
module pipe_stage_reg #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 24,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   input  logic              flush_i,
   output logic [1:0]        count_o
);
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKIDFULL = 2'd2} state_t;
   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_main_data, r_skid_data;
   logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
   logic              w_in_xfer, w_out_xfer, w_main_ld_in, w_main_ld_skid, w_skid_ld;
   // With SKID=1 ready depends only on held state, breaking the out_ready_i timing path
   assign in_ready_o  = (SKID != 0) ? (r_state != SKIDFULL) && !flush_i
                                    : ((r_state == EMPTY) || out_ready_i) && !flush_i;
   assign out_valid_o = r_state != EMPTY;
   assign w_in_xfer   = in_valid_i && in_ready_o;
   assign w_out_xfer  = out_valid_o && out_ready_i;
   assign count_o     = r_state;
   assign data_o      = r_main_data;
   assign ctrl_o      = out_valid_o ? r_main_ctrl : '0;
   always_comb begin
      w_next         = r_state;
      w_main_ld_in   = 1'b0;
      w_main_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;
      if (flush_i)
         w_next = EMPTY;
      else
         case (r_state)
            EMPTY: if (w_in_xfer) begin
               w_next       = FULL;
               w_main_ld_in = 1'b1;
            end
            FULL: if (w_in_xfer && w_out_xfer)
               w_main_ld_in = 1'b1;
            else if (w_in_xfer) begin
               w_next    = SKIDFULL;
               w_skid_ld = 1'b1;
            end else if (w_out_xfer)
               w_next = EMPTY;
            SKIDFULL: if (w_out_xfer) begin
               w_next         = FULL;
               w_main_ld_skid = 1'b1;
            end
            default: w_next = EMPTY;
         endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= EMPTY;
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         r_state <= w_next;
         if (w_main_ld_in) begin
            r_main_data <= data_i;
            r_main_ctrl <= ctrl_i;
         end else if (w_main_ld_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
         end
         if (w_skid_ld) begin
            r_skid_data <= data_i;
            r_skid_ctrl <= ctrl_i;
         end
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a SKID=1 and a SKID=0 instance with shared stimulus and
// checks both against a two-slot FIFO model every cycle.
module tb_pipe_stage_reg;
   localparam int DW = 96;
   localparam int CW = 24;
   logic clk = 1'b0, reset_n = 1'b0;
   logic in_valid_i = 1'b0, out_ready_i = 1'b0, flush_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic [CW-1:0] ctrl_i = '0;
   logic rdy0, rdy1, vld0, vld1;
   logic [DW-1:0] dout0, dout1;
   logic [CW-1:0] cout0, cout1;
   logic [1:0] cnt0, cnt1;
   int total = 0, bad = 0;
   int m_cnt [2];
   logic [DW-1:0] m_d [2][2];
   logic [CW-1:0] m_c [2][2];
   logic [DW-1:0] m_last [2];
   logic [DW-1:0] a_d = {3{32'hA0A0_0001}}, b_d = {3{32'hB0B0_0002}}, c_d = {3{32'hC0C0_0003}};
   logic did_rst = 1'b0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .in_ready_o(rdy1),
      .data_i(data_i), .ctrl_i(ctrl_i), .out_valid_o(vld1), .out_ready_i(out_ready_i),
      .data_o(dout1), .ctrl_o(cout1), .flush_i(flush_i), .count_o(cnt1));
   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid_i), .in_ready_o(rdy0),
      .data_i(data_i), .ctrl_i(ctrl_i), .out_valid_o(vld0), .out_ready_i(out_ready_i),
      .data_o(dout0), .ctrl_o(cout0), .flush_i(flush_i), .count_o(cnt0));

   always #5 clk = ~clk;

   task automatic cmp(input string n, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, a, e);
      end
   endtask

   function automatic logic m_rdy(input int k);
      return (k == 1) ? (m_cnt[k] < 2 && !flush_i) : ((m_cnt[k] == 0 || out_ready_i) && !flush_i);
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]  = 0;
         m_last[k] = '0;
      end
   endtask

   task automatic m_step(input int k);
      logic ix, ox;
      ix = in_valid_i && m_rdy(k);
      ox = m_cnt[k] > 0 && out_ready_i;
      if (flush_i)
         m_cnt[k] = 0;
      else begin
         if (ox) begin
            m_d[k][0] = m_d[k][1];
            m_c[k][0] = m_c[k][1];
            m_cnt[k]--;
         end
         if (ix) begin
            m_d[k][m_cnt[k]] = data_i;
            m_c[k][m_cnt[k]] = ctrl_i;
            m_cnt[k]++;
         end
      end
      if (m_cnt[k] > 0) m_last[k] = m_d[k][0];
   endtask

   task automatic chk_out(input int k, input logic v, input logic [DW-1:0] d,
                          input logic [CW-1:0] c, input logic [1:0] n);
      cmp($sformatf("valid%0d", k), v, m_cnt[k] > 0);
      cmp($sformatf("data%0d", k), d, m_cnt[k] > 0 ? m_d[k][0] : m_last[k]);
      cmp($sformatf("ctrl%0d", k), c, m_cnt[k] > 0 ? m_c[k][0] : '0);
      cmp($sformatf("count%0d", k), n, m_cnt[k][1:0]);
   endtask

   // Inputs are applied at the falling edge; ready is checked just after, outputs at the next falling edge.
   task automatic step();
      #1;
      cmp("rdy1", rdy1, m_rdy(1));
      cmp("rdy0", rdy0, m_rdy(0));
      m_step(0);
      m_step(1);
      @(negedge clk);
      chk_out(1, vld1, dout1, cout1, cnt1);
      chk_out(0, vld0, dout0, cout0, cnt0);
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      cmp("rst_valid", vld1, 1'b0);
      cmp("rst_data", dout1, '0);
      cmp("rst_ctrl", cout1, '0);
      cmp("rst_count", cnt1, 2'd0);
      cmp("rst_ready", rdy1, 1'b1);
      reset_n = 1'b1;
      in_valid_i = 1'b1; data_i = {12{8'hAA}}; ctrl_i = 24'h000123; out_ready_i = 1'b1;
      step();
      cmp("first_valid", vld1, 1'b1);
      cmp("first_data", dout1, {12{8'hAA}});
      cmp("first_ctrl", cout1, 24'h000123);
      cmp("first_count", cnt1, 2'd1);
      in_valid_i = 1'b0; flush_i = 1'b1;
      step();
      flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b1; data_i = a_d; ctrl_i = 24'h00000A;
      step();
      data_i = b_d; ctrl_i = 24'h00000B;
      step();
      cmp("skid_count2", cnt1, 2'd2);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      #1;
      cmp("skid_ready0", rdy1, 1'b0);
      cmp("skid_headA", dout1, a_d);
      step();
      cmp("skid_headB", dout1, b_d);
      cmp("skid_ctrlB", cout1, 24'h00000B);
      step();
      cmp("skid_drained", cnt1, 2'd0);
      out_ready_i = 1'b0; in_valid_i = 1'b1; data_i = a_d; ctrl_i = 24'h00000A;
      step();
      data_i = b_d; ctrl_i = 24'h00000B;
      step();
      cmp("fl_count2", cnt1, 2'd2);
      flush_i = 1'b1; data_i = c_d; ctrl_i = 24'h00000C;
      step();
      cmp("fl_valid", vld1, 1'b0);
      cmp("fl_ctrl", cout1, '0);
      cmp("fl_count", cnt1, 2'd0);
      cmp("fl_data_held", dout1, a_d);
      flush_i = 1'b0; data_i = a_d; ctrl_i = 24'h00000A;
      step();
      data_i = b_d; ctrl_i = 24'h00000B; out_ready_i = 1'b1;
      #1;
      cmp("s0_ready", rdy0, 1'b1);
      step();
      cmp("s0_valid", vld0, 1'b1);
      cmp("s0_data", dout0, b_d);
      cmp("s0_count", cnt0, 2'd1);
      for (int i = 0; i < 10000; i++) begin
         in_valid_i  = $urandom_range(0, 9) < 7;
         out_ready_i = $urandom_range(0, 9) < 5;
         flush_i     = $urandom_range(0, 63) == 0;
         data_i      = {$urandom, $urandom, $urandom};
         ctrl_i      = CW'($urandom);
         step();
         if (!did_rst && i > 3000 && m_cnt[1] == 2) begin
            did_rst = 1'b1;
            in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
            #2 reset_n = 1'b0;
            #1;
            cmp("arst_valid", vld1, 1'b0);
            cmp("arst_data", dout1, '0);
            cmp("arst_ctrl", cout1, '0);
            cmp("arst_count", cnt1, 2'd0);
            cmp("arst_ready", rdy1, 1'b1);
            cmp("arst_count0", cnt0, 2'd0);
            m_reset();
            @(negedge clk);
            reset_n = 1'b1;
         end
      end
      cmp("arst_reached", did_rst, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, width of the operand payload (e.g. pc, rs1, rs2).
REQ-002 Parameter CTRL_W, default 24, width of the control payload (op codes, write enables, destination addresses).
REQ-003 Parameter SKID, default 1; 1 selects the two-entry skid buffer with ready decoupled from out_ready_i, 0 selects single-entry mode.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid_i  input  1  upstream stage offers an instruction.
REQ-007 in_ready_o  output  1  block accepts an instruction this cycle.
REQ-008 data_i  input  DATA_W  incoming operand payload.
REQ-009 ctrl_i  input  CTRL_W  incoming control payload.
REQ-010 out_valid_o  output  1  head entry is valid.
REQ-011 out_ready_i  input  1  downstream stage consumes the head entry.
REQ-012 data_o  output  DATA_W  head operand payload.
REQ-013 ctrl_o  output  CTRL_W  head control payload; forced to all zero (bubble/NOP) whenever out_valid_o=0.
REQ-014 flush_i  input  1  synchronous kill of all held entries (branch redirect).
REQ-015 count_o  output  2  number of valid entries held (0..2; at most 1 when SKID=0).

Function
REQ-016 An input transfer occurs on a cycle with in_valid_i=1, in_ready_o=1 and flush_i=0; an output transfer occurs on a cycle with out_valid_o=1 and out_ready_i=1.
REQ-017 States: EMPTY (count 0), FULL (count 1, main entry valid), SKIDFULL (count 2, main and skid valid); SKIDFULL is unreachable when SKID=0.
REQ-018 EMPTY: input transfer -> FULL, main<=input; otherwise hold.
REQ-019 FULL: input and output transfer -> FULL, main<=input; input only -> SKIDFULL (SKID=1, skid<=input); output only -> EMPTY; neither -> hold with main unchanged.
REQ-020 SKIDFULL: output transfer -> FULL, main<=skid; otherwise hold; no input is accepted.
REQ-021 SKID=1: in_ready_o = (state != SKIDFULL) and !flush_i; in_ready_o has no combinational path from out_ready_i.
REQ-022 SKID=0: in_ready_o = ((state==EMPTY) or out_ready_i) and !flush_i.
REQ-023 Latency: an instruction accepted on cycle N appears on outputs with out_valid_o=1 on cycle N+1.
REQ-024 Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
REQ-025 flush_i=1: next state EMPTY from any state, count_o=0 next cycle, and no input transfer occurs that cycle.
REQ-026 An output transfer in the flush cycle counts as completed.
REQ-027 Flush has priority over all simultaneous input and output transfers.
REQ-028 data_o holds its last value when emptied or flushed (no toggling); ctrl_o reads zero.
REQ-029 count_o equals the state encoding at all times; data_o and ctrl_o always present the main entry.

Reset
REQ-030 While reset_n=0 and after release: state EMPTY, out_valid_o=0, count_o=0, data_o=0, ctrl_o=0, and the main and skid storage are zero.
REQ-031 in_ready_o=1 after reset (flush_i=0); assertion mid-operation discards all entries immediately and asynchronously.

Verification
REQ-032 Reset, then in_valid_i=1 with data_i=0x...AA, ctrl_i=0x000123, out_ready_i=1 -> next cycle out_valid_o=1, data_o=0x...AA, ctrl_o=0x000123, count_o=1.
REQ-033 SKID=1: fill with A and B while out_ready_i=0 -> count_o=2 and in_ready_o=0. Raise out_ready_i -> A, then B on consecutive cycles, then count_o=0.
REQ-034 SKID=0: FULL with out_ready_i=1 and in_valid_i=1 -> in_ready_o=1 in the same cycle, and the new entry replaces the head with no bubble.
REQ-035 SKIDFULL with flush_i=1, in_valid_i=1 and out_ready_i=0 -> next cycle out_valid_o=0, ctrl_o=0, count_o=0, and the offered input is not stored.
REQ-036 Random valid/ready/flush streams of 10k cycles vs a scoreboard model -> ordering, no loss or duplication, ctrl_o=0 whenever out_valid_o=0.
REQ-037 Drop reset_n mid-stream with count_o=2 -> outputs are zero and in_ready_o=1 with no clock edge required; streaming resumes cleanly after release.
